// File: rtl/dram_pkg.sv
// Shared types and helpers for the two-bank DRAM sequencer.
package dram_pkg;

  typedef enum logic [2:0] {
    IDLE, ROW, COL, ACK, PRE, REF0, REF1, REF2
  } dramState_e;

  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_3BYTE = 2'b11;

  // cpuAddr carries A[24:2]
  localparam int BANK_BIT = 22;
  localparam int ROW_MSB  = 21;
  localparam int ROW_LSB  = 11;
  localparam int COL_MSB  = 10;
  localparam int COL_LSB  = 0;

  // Active-high lane enables; bit n is lane n. Transfers never wrap past lane 3.
  function automatic logic [3:0] laneMask(input logic [1:0] siz, input logic [1:0] lo);
    logic [3:0] base;
    case (siz)
      SIZ_BYTE:  base = 4'b0001;
      SIZ_WORD:  base = 4'b0011;
      SIZ_3BYTE: base = 4'b0111;
      default:   base = 4'b1111;
    endcase
    return base << lo;
  endfunction

endpackage

// File: rtl/dram_if.sv
// Bus-controller side request/ack plus the DRAM pin bundle.
interface dram_if;
  // Handshake: the bus controller drops ramCEn with address/size/direction
  // stable and holds it until it has seen ramACKn low (or aborts by raising
  // it early); the controller raises ramACKn once ramCEn is sampled high.
  logic        ramCEn;
  logic [22:0] cpuAddr;
  logic [1:0]  cpuAddrLo;
  logic [1:0]  cpuSIZ;
  logic        cpuRWn;
  logic        ramACKn;
  logic [10:0] dramMA;
  logic [1:0]  dramRASn;
  logic [3:0]  dramCASn;
  logic        dramWEn;
  logic        refOverrun;

  modport master (
    output ramCEn, cpuAddr, cpuAddrLo, cpuSIZ, cpuRWn,
    input  ramACKn, dramMA, dramRASn, dramCASn, dramWEn, refOverrun
  );

  modport slave (
    input  ramCEn, cpuAddr, cpuAddrLo, cpuSIZ, cpuRWn,
    output ramACKn, dramMA, dramRASn, dramCASn, dramWEn, refOverrun
  );
endinterface

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval timer with request/acknowledge and overrun flag.
module dram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 250
) (
    input  logic sysClk,
    input  logic sysRESETn,
    input  logic refAck,
    output logic refReq,
    output logic refOverrun
);

    localparam int CW = $clog2(REFRESH_INTERVAL);
    localparam logic [CW-1:0] RELOAD = CW'(REFRESH_INTERVAL - 1);

    logic [CW-1:0] refCnt;
    logic          expire;

    assign expire = (refCnt == '0);

    always_ff @(posedge sysClk or negedge sysRESETn) begin
        if (!sysRESETn) begin
            refCnt     <= RELOAD;
            refReq     <= 1'b0;
            refOverrun <= 1'b0;
        end else begin
            refCnt <= expire ? RELOAD : refCnt - 1'b1;
            // A new expiry outranks a same-cycle acknowledge, so nothing is dropped silently
            if (expire) begin
                refReq <= 1'b1;
                if (refReq && !refAck) refOverrun <= 1'b1;
            end else if (refAck) begin
                refReq <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// CPU/refresh sequencer for the two-bank DRAM array; all pins are registered
// and loaded from nextState so they switch on the edge the state is entered.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = 250,
    parameter int RAS_PRECHARGE    = 2
) (
    input  logic       sysClk,
    input  logic       sysRESETn,
    dram_if.slave      bus,
    output dramState_e dbgState
);

    localparam int PW = (RAS_PRECHARGE > 1) ? $clog2(RAS_PRECHARGE) : 1;
    localparam logic [PW-1:0] PRE_RELOAD = PW'(RAS_PRECHARGE - 1);

    dramState_e  state, nextState;
    logic [PW-1:0] preCnt;
    logic        refReq, refAck, refOverrun;

    logic        ackNReg, nxtAckN;
    logic [1:0]  rasNReg, nxtRASn;
    logic [3:0]  casNReg, nxtCASn;
    logic        weNReg,  nxtWEn;
    logic [10:0] maReg,   nxtMA;

    assign refAck = (state == IDLE) && refReq;

    dram_refresh_timer #(.REFRESH_INTERVAL(REFRESH_INTERVAL)) uTimer (
        .sysClk     (sysClk),
        .sysRESETn  (sysRESETn),
        .refAck     (refAck),
        .refReq     (refReq),
        .refOverrun (refOverrun)
    );

    always_ff @(posedge sysClk or negedge sysRESETn) begin
        if (!sysRESETn) begin
            state   <= IDLE;
            preCnt  <= PRE_RELOAD;
            ackNReg <= 1'b1;
            rasNReg <= 2'b11;
            casNReg <= 4'hF;
            weNReg  <= 1'b1;
            maReg   <= '0;
        end else begin
            state   <= nextState;
            ackNReg <= nxtAckN;
            rasNReg <= nxtRASn;
            casNReg <= nxtCASn;
            weNReg  <= nxtWEn;
            maReg   <= nxtMA;
            if (nextState == PRE && state != PRE) preCnt <= PRE_RELOAD;
            else if (state == PRE)                preCnt <= preCnt - 1'b1;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (refReq) nextState = REF0;
                     else if (!bus.ramCEn) nextState = ROW;
            ROW:     nextState = bus.ramCEn ? PRE : COL;
            COL:     nextState = bus.ramCEn ? PRE : ACK;
            ACK:     if (bus.ramCEn) nextState = PRE;
            PRE:     if (preCnt == '0) nextState = IDLE;
            REF0:    nextState = REF1;
            REF1:    nextState = REF2;
            REF2:    nextState = PRE;
            default: nextState = IDLE;
        endcase
    end

    // Unlisted pins hold, which keeps RAS/CAS/WE/MA steady from COL into ACK
    always_comb begin
        nxtAckN = 1'b1;
        nxtRASn = rasNReg;
        nxtCASn = casNReg;
        nxtWEn  = weNReg;
        nxtMA   = maReg;
        case (nextState)
            ROW: begin
                nxtMA   = bus.cpuAddr[ROW_MSB:ROW_LSB];
                nxtRASn = bus.cpuAddr[BANK_BIT] ? 2'b01 : 2'b10;
                nxtCASn = 4'hF;
                nxtWEn  = bus.cpuRWn;
            end
            COL: begin
                nxtMA   = bus.cpuAddr[COL_MSB:COL_LSB];
                nxtCASn = weNReg ? 4'h0 : ~laneMask(bus.cpuSIZ, bus.cpuAddrLo);
            end
            ACK:  nxtAckN = 1'b0;
            REF0: begin
                nxtRASn = 2'b11;
                nxtCASn = 4'h0;
                nxtWEn  = 1'b1;
            end
            REF1: begin
                nxtRASn = 2'b00;
                nxtCASn = 4'h0;
            end
            REF2: begin
                nxtRASn = 2'b00;
                nxtCASn = 4'hF;
            end
            default: begin
                nxtRASn = 2'b11;
                nxtCASn = 4'hF;
                nxtWEn  = 1'b1;
            end
        endcase
    end

    assign bus.ramACKn    = ackNReg;
    assign bus.dramRASn   = rasNReg;
    assign bus.dramCASn   = casNReg;
    assign bus.dramWEn    = weNReg;
    assign bus.dramMA     = maReg;
    assign bus.refOverrun = refOverrun;
    assign dbgState       = state;

endmodule
